lfsr_crc_check: RTL and testbench
=================================

# lfsr_crc_check

Receive-side CRC checker for byte streams carrying an appended FCS; the counterpart to the `lfsr_crc` generator. It computes the CRC over each frame, FCS bytes included, one byte per cycle, and compares the final register against the fixed residue. It strips the trailing FCS bytes from the forwarded stream and issues a per-frame status pulse (good / bad CRC / runt). It sits between a byte-wide receive datapath and the frame consumer.

## Interface
- `LFSR_WIDTH`, 32: CRC width; equals FCS length in bits; FCS_BYTES = LFSR_WIDTH/8.
- `LFSR_POLY`, 32'h04c11db7: generator polynomial, normal (non-reflected) form.
- `LFSR_INIT`, all ones: CRC register value at frame start.
- `REVERSE`, 1: bit-reflected (LSB-first) processing of data and register.
- `RESIDUE`, 32'hdebb20e3: raw register value, before any inversion, that marks a valid frame.
- `MIN_LEN`, 64: minimum frame length in bytes, FCS included; shorter frames are runts.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in 8: input byte.
- `s_valid` in 1: input byte valid.
- `s_ready` out 1: block accepts input byte.
- `s_last` in 1: input byte is the last byte of the frame (last FCS byte).
- `m_data` out 8: payload byte out.
- `m_valid` out 1: output byte valid.
- `m_ready` in 1: downstream accepts output byte.
- `m_last` out 1: final payload byte of the frame.
- `status_valid` out 1: one-cycle pulse, frame verdict.
- `status_good` out 1: CRC matches and length is at least MIN_LEN; qualified by `status_valid`.
- `status_bad_crc` out 1: residue mismatch; qualified by `status_valid`.
- `status_runt` out 1: length below MIN_LEN; qualified by `status_valid`.

## Operation
- An input transfer occurs when `s_valid && s_ready`. Output transfer occurs when `m_valid && m_ready`.
- CRC register:
  - Loads LFSR_INIT on reset and after each last byte.
  - Updates by one byte per input transfer, Galois form, per POLY and REVERSE.
  - The verdict uses the register value after the last byte has been applied.
- Delay buffer: FCS_BYTES-deep shift register plus a `cnt` field (0..FCS_BYTES).
  - While `cnt` < FCS_BYTES, an accepted byte is stored and `cnt` increments.
  - When `cnt` = FCS_BYTES, an accepted byte shifts in and the oldest byte loads the output register.
- On an input transfer with `s_last`:
  - If `cnt` = FCS_BYTES, the evicted byte is output with `m_last`=1.
  - If `cnt` < FCS_BYTES, no output byte is produced, because there is no payload.
  - Buffer `cnt` clears to 0 and the CRC reloads.
- Length counter: 16 bits, saturating at 0xFFFF, counts accepted bytes of the current frame, and clears after the last byte.
- Verdict on the last byte, using length L including the last byte:
  - `runt` = (L < MIN_LEN).
  - `bad_crc` = (CRC register != RESIDUE).
  - `good` = !runt && !bad_crc.
  - `runt` and `bad_crc` may both be set.
- `s_ready` = (`cnt` < FCS_BYTES) || !`m_valid` || `m_ready`. This is combinational from `m_ready`; there is no combinational path from `s_valid`.
- Output register holds `m_data`/`m_last` stable while `m_valid && !m_ready`.
- Reset mid-frame discards the partial frame. No status pulse is issued for it, and the next accepted byte starts a new frame.

## Timing
- Reset values:
  - `m_valid`=0, `m_last`=0, `m_data`=0.
  - `status_valid`=0, `status_good`=0, `status_bad_crc`=0, `status_runt`=0.
  - `cnt`=0, length=0, CRC=LFSR_INIT.
  - `s_ready`=1 after reset.
- Latency: payload byte k (1-based) appears on `m_data` the cycle after input byte k+FCS_BYTES is accepted.
  - At full rate with `m_ready`=1, this is a 4-cycle delay with 32-bit CRC.
- Status: `status_valid` is high for exactly one cycle, the cycle after the last-byte transfer. Status flags hold their value until the next pulse.
- The status pulse is independent of `m_ready`. It may precede acceptance of the `m_last` byte.
- Back-to-back frames: the first byte of the next frame may be accepted the cycle after `s_last`.
- Throughput: one byte per cycle when `m_ready`=1.

## Test plan
- ASCII "123456789" followed by 26 39 F4 CB, with `MIN_LEN`=5 and `m_ready`=1:
  - Output is exactly 31..39 with `m_last` on 0x39.
  - `status_good`=1, one `status_valid` pulse.
- Same frame with byte 3 corrupted to 0x34: identical output timing, `status_bad_crc`=1, `status_good`=0.
- Default `MIN_LEN`=64 with the 13-byte frame above: `status_runt`=1, `status_bad_crc`=0. A 3-byte frame produces no `m_valid` and gives `runt`=1, `bad_crc`=1.
- Random `m_ready` (50%) and random `s_valid` gaps over 100 frames of lengths 5–1518 with correct FCS:
  - Output stream equals the payloads byte-exact.
  - All frames good; `s_ready` deasserts only when buffer full and output stalled.
- Assert `rst` after 7 bytes of a frame, then send the valid 13-byte frame: no status for the aborted frame, and the second frame gives `good`=1.
- Two valid frames back-to-back, with `s_valid` held high across the boundary: two status pulses 13 cycles apart, and both payloads are correct with `m_last` on each final byte.

Source files
------------

// File: rtl/lfsr_crc_check.sv
// Receive CRC checker: checks the appended FCS, strips it, and pulses a per-frame verdict.
// Latency: payload byte k is presented the cycle after input byte k+FCS_BYTES; status the cycle after s_last.
// Backpressure: s_ready drops only while the delay line is full and the output register is stalled.
module lfsr_crc_check #(
    parameter int                    LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04c11db7,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = '1,
    parameter bit                    REVERSE    = 1'b1,
    parameter logic [LFSR_WIDTH-1:0] RESIDUE    = 32'hdebb20e3,
    parameter int                    MIN_LEN    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_last,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       status_valid,
    output logic       status_good,
    output logic       status_bad_crc,
    output logic       status_runt
);

    localparam int FCS_BYTES = LFSR_WIDTH / 8;
    localparam int CW        = $clog2(FCS_BYTES + 1);

    function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
        logic [LFSR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < LFSR_WIDTH; i++) begin
            r[i] = v[LFSR_WIDTH-1-i];
        end
        return r;
    endfunction

    localparam logic [LFSR_WIDTH-1:0] POLY_REF = reflect(LFSR_POLY);

    // Galois update, one data bit per step; the reflected variant shifts right with the mirrored polynomial.
    function automatic logic [LFSR_WIDTH-1:0] crc_byte(input logic [LFSR_WIDTH-1:0] c,
                                                       input logic [7:0]            d);
        logic [LFSR_WIDTH-1:0] r;
        logic                  fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (REVERSE) begin
                fb = r[0] ^ d[i];
                r  = r >> 1;
                if (fb) r = r ^ POLY_REF;
            end else begin
                fb = r[LFSR_WIDTH-1] ^ d[7-i];
                r  = r << 1;
                if (fb) r = r ^ LFSR_POLY;
            end
        end
        return r;
    endfunction

    logic [7:0]            dly [FCS_BYTES];
    logic [CW-1:0]         cnt;
    logic [LFSR_WIDTH-1:0] crc;
    logic [LFSR_WIDTH-1:0] crc_nxt;
    logic [15:0]           len;
    logic [15:0]           len_nxt;
    logic                  buf_full;
    logic                  xfer;
    logic                  runt_nxt;
    logic                  bad_nxt;

    assign buf_full = (cnt == CW'(FCS_BYTES));
    assign s_ready  = !buf_full || !m_valid || m_ready;
    assign xfer     = s_valid && s_ready;

    always_comb begin
        crc_nxt  = crc_byte(crc, s_data);
        len_nxt  = (len == 16'hffff) ? len : len + 16'd1;
        runt_nxt = ({16'd0, len_nxt} < 32'(MIN_LEN));
        bad_nxt  = (crc_nxt != RESIDUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FCS_BYTES; i++) begin
                dly[i] <= 8'd0;
            end
            cnt            <= '0;
            crc            <= LFSR_INIT;
            len            <= 16'd0;
            m_data         <= 8'd0;
            m_valid        <= 1'b0;
            m_last         <= 1'b0;
            status_valid   <= 1'b0;
            status_good    <= 1'b0;
            status_bad_crc <= 1'b0;
            status_runt    <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (xfer) begin
                dly[0] <= s_data;
                for (int i = 1; i < FCS_BYTES; i++) begin
                    dly[i] <= dly[i-1];
                end
                // Once FCS_BYTES are held, the oldest byte is known to be payload.
                if (buf_full) begin
                    m_data  <= dly[FCS_BYTES-1];
                    m_last  <= s_last;
                    m_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                if (s_last) begin
                    cnt            <= '0;
                    crc            <= LFSR_INIT;
                    len            <= 16'd0;
                    status_valid   <= 1'b1;
                    status_good    <= !runt_nxt && !bad_nxt;
                    status_bad_crc <= bad_nxt;
                    status_runt    <= runt_nxt;
                end else begin
                    crc <= crc_nxt;
                    len <= len_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_crc_check.sv
// Randomized bench for lfsr_crc_check against a table-driven CRC-32 frame model; two instances (MIN_LEN 5 and 64).
module tb_lfsr_crc_check;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       m_ready = 1'b1;
    logic       rnd_mode = 1'b0;

    logic       s_ready_a, m_valid_a, m_last_a, st_vld_a, st_good_a, st_bad_a, st_runt_a;
    logic [7:0] m_data_a;
    logic       s_ready_b, m_valid_b, m_last_b, st_vld_b, st_good_b, st_bad_b, st_runt_b;
    logic [7:0] m_data_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] tab [256];
    logic [8:0]  exp_q [$];
    logic [5:0]  st_q [$];
    int          pulses [$];
    logic [2:0]  last_a = 3'd0;
    logic [2:0]  last_b = 3'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lfsr_crc_check #(.MIN_LEN(5)) dut_a (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a), .s_last(s_last),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_last(m_last_a),
        .status_valid(st_vld_a), .status_good(st_good_a),
        .status_bad_crc(st_bad_a), .status_runt(st_runt_a)
    );

    lfsr_crc_check dut_b (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b), .s_last(s_last),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_last(m_last_b),
        .status_valid(st_vld_b), .status_good(st_good_b),
        .status_bad_crc(st_bad_b), .status_runt(st_runt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] raw_crc(input bq_t f);
        logic [31:0] c;
        c = 32'hffffffff;
        foreach (f[i]) c = tab[c[7:0] ^ f[i]] ^ (c >> 8);
        return c;
    endfunction

    function automatic bq_t make_frame(input int total_len);
        bq_t         f;
        logic [31:0] fcs;
        for (int i = 0; i < total_len - 4; i++) f.push_back(8'($urandom_range(0, 255)));
        fcs = ~raw_crc(f);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        return f;
    endfunction

    task automatic queue_frame(input bq_t f);
        int   l;
        logic bad;
        logic r5;
        logic r64;
        l   = f.size();
        bad = (raw_crc(f) != 32'hdebb20e3);
        r5  = (l < 5);
        r64 = (l < 64);
        for (int i = 0; i < l - 4; i++) exp_q.push_back({(i == l - 5), f[i]});
        st_q.push_back({!r5 && !bad, bad, r5, !r64 && !bad, bad, r64});
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic gaps);
        int  w;
        logic done;
        if (gaps && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        w = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (s_ready_a) done = 1'b1;
            else if (++w > 2000) begin
                check("s_ready_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input bq_t f, input logic gaps);
        queue_frame(f);
        for (int i = 0; i < f.size(); i++) send_byte(f[i], (i == f.size() - 1), gaps);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || st_q.size() != 0) && w < 20000) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_outstanding", 32'(exp_q.size() + st_q.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Cycle monitor: expectations set on one falling edge are checked on the next.
    initial begin
        int         mcnt;
        logic       pend_pulse, pend_load, hold_v;
        logic [8:0] hold_d, e;
        logic [5:0] es;
        logic       srdy_exp;
        mcnt = 0; pend_pulse = 1'b0; pend_load = 1'b0; hold_v = 1'b0; hold_d = 9'd0;
        forever begin
            @(negedge clk);
            if (hold_v) begin
                check("hold_valid", 32'(m_valid_a), 32'd1);
                check("hold_data", 32'({m_last_a, m_data_a}), 32'(hold_d));
            end
            if (pend_load) check("latency_valid", 32'(m_valid_a), 32'd1);
            check("status_pulse_a", 32'(st_vld_a), 32'(pend_pulse));
            check("status_pulse_b", 32'(st_vld_b), 32'(pend_pulse));
            if (st_vld_a) begin
                last_a = {st_good_a, st_bad_a, st_runt_a};
                last_b = {st_good_b, st_bad_b, st_runt_b};
                pulses.push_back(cyc);
                if (st_q.size() == 0) check("status_unexpected", 32'd1, 32'd0);
                else begin
                    es = st_q.pop_front();
                    check("status_flags", 32'({last_a, last_b}), 32'(es));
                end
            end
            srdy_exp = (mcnt < 4) || !m_valid_a || m_ready;
            check("s_ready_a", 32'(s_ready_a), 32'(srdy_exp));
            check("s_ready_b", 32'(s_ready_b), 32'(srdy_exp));
            hold_v = m_valid_a && !m_ready && !rst;
            hold_d = {m_last_a, m_data_a};
            if (rst) begin
                mcnt = 0; pend_pulse = 1'b0; pend_load = 1'b0; hold_v = 1'b0;
            end else begin
                pend_load  = s_valid && s_ready_a && (mcnt >= 4);
                pend_pulse = s_valid && s_ready_a && s_last;
                if (s_valid && s_ready_a) mcnt = s_last ? 0 : ((mcnt < 4) ? mcnt + 1 : 4);
                if (m_valid_a && m_ready) begin
                    if (exp_q.size() == 0) check("output_unexpected", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        check("m_data", 32'({m_last_a, m_data_a}), 32'(e));
                        check("m_data_b", 32'({m_valid_b, m_last_b, m_data_b}), 32'({1'b1, e}));
                    end
                end
            end
        end
    end

    initial begin
        bq_t f1, f2, f3, fr;
        int  np;
        int  len;
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
            tab[n] = c;
        end
        f1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hf4, 8'hcb};
        f2 = f1;
        f2[2] = 8'h34;
        f3 = '{8'h01, 8'h02, 8'h03};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_m_valid", 32'(m_valid_a), 32'd0);
        check("reset_m_last", 32'(m_last_a), 32'd0);
        check("reset_m_data", 32'(m_data_a), 32'd0);
        check("reset_status", 32'({st_vld_a, st_good_a, st_bad_a, st_runt_a}), 32'd0);
        check("reset_s_ready", 32'(s_ready_a), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        np = pulses.size();
        send_frame(f1, 1'b0);
        idle(4);
        drain();
        check("check_string_pulses", 32'(pulses.size() - np), 32'd1);
        check("check_string_good", 32'(last_a), 32'b100);
        check("check_string_runt64", 32'(last_b), 32'b001);

        send_frame(f2, 1'b0);
        idle(4);
        drain();
        check("corrupt_bad_crc", 32'(last_a), 32'b010);

        send_frame(f3, 1'b0);
        idle(4);
        drain();
        check("three_byte_runt_bad", 32'(last_a), 32'b011);

        // Aborted frame: three payload bytes escape before reset, no verdict follows.
        fr = make_frame(20);
        np = pulses.size();
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, fr[i]});
        for (int i = 0; i < 7; i++) send_byte(fr[i], 1'b0, 1'b0);
        idle(3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        check("abort_no_status", 32'(pulses.size()), 32'(np));
        send_frame(f1, 1'b0);
        idle(4);
        drain();
        check("after_abort_good", 32'(last_a), 32'b100);

        np = pulses.size();
        send_frame(f1, 1'b0);
        send_frame(f1, 1'b0);
        idle(4);
        drain();
        if (pulses.size() >= np + 2)
            check("back_to_back_gap", 32'(pulses[np+1] - pulses[np]), 32'd13);
        else
            check("back_to_back_pulses", 32'(pulses.size() - np), 32'd2);

        rnd_mode = 1'b1;
        for (int fi = 0; fi < 100; fi++) begin
            case (fi)
                0:       len = 5;
                1:       len = 1518;
                2:       len = 63;
                3:       len = 64;
                default: len = $urandom_range(5, 200);
            endcase
            send_frame(make_frame(len), 1'b1);
        end
        idle(2);
        rnd_mode = 1'b0;
        drain();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
